fpu_multicycle: RTL and testbench
=================================

# fpu_multicycle

Parametrised, multi-cycle IEEE-754 floating-point unit performing ADD, SUB and MUL with valid/ready handshakes on both sides. It is the sequential successor to the combinational `fpu`, and adds five things that block lacks: configurable exponent and fraction widths, guard/round/sticky round-to-nearest-even, special-value handling, exception flags, and a fixed-latency FSM. It sits between the `h2bp` register file and writeback, and stalls cleanly on back-pressure.

## Interface
- `EXP_W`, default 8, exponent width; `BIAS` = 2^(EXP_W-1)-1.
- `FRAC_W`, default 23, stored fraction width; word width `W` = 1+EXP_W+FRAC_W.
- `clk` input 1: the only clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: an operation is offered.
- `in_ready` output 1: the block accepts an operation this cycle.
- `operation` input 3: `h2bp` opcode (`opADD`, `opSUB`, `opMUL`).
- `operand_a` input W: first operand.
- `operand_b` input W: second operand.
- `out_valid` output 1: `result` and `flags` are valid.
- `out_ready` input 1: the consumer takes the result.
- `result` output W: rounded result.
- `flags` output 4: {invalid, overflow, underflow, inexact}.

## Operation
- FSM states are IDLE, ALIGN, COMPUTE, NORM, ROUND, OUTPUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, register the operation and operands, then go to ALIGN.
- ALIGN:
  - Unpack each operand. exp==0 means zero; denormal inputs are flushed to ±0. exp==all-ones means inf (fraction 0) or NaN.
  - For SUB, invert the sign of b.
  - ADD/SUB: swap so that |a| ≥ |b|, then right-shift b's mantissa (hidden bit included) by the exponent difference.
  - The shifted mantissa carries 3 extra bits (guard, round, sticky). Sticky is the OR of all bits shifted out.
  - A shift ≥ FRAC_W+3 leaves only sticky.
- COMPUTE:
  - ADD/SUB: add or subtract magnitudes according to the effective signs, using a carry bit.
  - MUL: form the (FRAC_W+1)² product; exponent = ea+eb-BIAS; sign = sa^sb.
- NORM:
  - If a carry occurred, right-shift by 1 (into sticky) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count from `fpu_lzc` and decrement the exponent by the same amount.
- ROUND:
  - Round to nearest, ties to even, on guard/round/sticky. `inexact` = any of them set.
  - A mantissa carry-out from rounding renormalises and increments the exponent.
  - Exponent ≥ 2^EXP_W-1 gives ±inf, with `overflow` and `inexact` set.
  - Exponent ≤ 0 with a nonzero value gives ±0, with `underflow` and `inexact` set.
- OUTPUT:
  - `out_valid`=1; `result` and `flags` are held stable.
  - On `out_ready`, go to IDLE.
- Special values (resolved in ALIGN, carried to OUTPUT without changing latency):
  - A NaN input gives canonical qNaN (sign 0, exp all-ones, fraction MSB 1); flags all 0.
  - inf-inf (effective) or 0×inf gives qNaN with `invalid` set.
  - An inf operand otherwise gives the correctly signed inf; flags 0.
- Zero sign rules:
  - Exact cancellation gives +0.
  - (-0)+(-0) gives -0.
  - MUL zero sign = sa^sb.
- An unsupported opcode gives `result`=0 and `invalid`=1.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `flags`=0.
- Latency is fixed for every op and every special case: acceptance edge t → `out_valid` high after edge t+4.
- `in_ready` is high only in IDLE. Minimum issue interval is 6 cycles (5 states plus the return to IDLE).
- An output handshake completes on a cycle with `out_valid` & `out_ready`. `out_ready` high on the first OUTPUT cycle returns the FSM to IDLE on the next edge.
- While `out_ready`=0 the FSM stays in OUTPUT indefinitely; `result` and `flags` must not change.
- Operand inputs are ignored outside the IDLE handshake cycle.
- `rst_n` low in any state immediately forces the reset values. The in-flight operation is dropped and never appears on the output.

## Structure
- The `h2bp` package gains `opMUL` alongside `opADD`/`opSUB`.
- The package also gains `fpu_state_t` (FSM enum) and `fpu_flags_t` (packed struct {invalid, overflow, underflow, inexact}).
- The existing `float` typedef stays as the EXP_W=8/FRAC_W=23 view; the ports are plain W-bit vectors.
- Sub-module `fpu_lzc`: parametrised combinational leading-zero counter, used in NORM.

## Test plan
- Basic ADD and MUL (default parameters):
  - ADD 0x3F800000+0x40000000 → 0x40400000, flags 0, `out_valid` exactly 4 edges after acceptance.
  - MUL 0x3FC00000×0x40000000 → 0x40400000, flags 0.
- Zeros:
  - SUB 0x3F800000-0x3F800000 → 0x00000000.
  - ADD 0x80000000+0x80000000 → 0x80000000.
  - MUL 0x80000000×0x3F800000 → 0x80000000.
- Rounding:
  - ADD 0x3F800000+0x33800000 → 0x3F800000, inexact=1.
  - ADD 0x3F800001+0x33800000 → 0x3F800002, inexact=1.
- Exceptions:
  - MUL 0x7F000000×0x40000000 → 0x7F800000, overflow=inexact=1.
  - MUL 0x00800000×0x00800000 → 0x00000000, underflow=inexact=1.
  - ADD 0x7F800000+0xFF800000 → 0x7FC00000, invalid=1.
- Handshake and reset:
  - Hold `out_ready`=0 for 10 cycles → `out_valid`, `result`, `flags` stable and `in_ready`=0 throughout.
  - Pulse `rst_n` low during COMPUTE → `out_valid` stays 0, `in_ready`=1 after release, the next op completes correctly.
- Parametrisation: repeat the basic ADD and MUL cases with EXP_W=5/FRAC_W=10 (half precision): 0x3C00+0x4000 → 0x4200; 0x3E00×0x4000 → 0x4200.

Source files
------------

// File: rtl/h2bp_pkg.sv
// Shared types for the h2bp datapath: opcodes, the single-precision float
// view, and the FSM state and exception flag types of the multi-cycle FPU.
package h2bp_pkg;

  typedef enum logic [2:0] {
    opADD = 3'd0,
    opSUB = 3'd1,
    opMUL = 3'd2
  } opcode_t;

  // Single-precision view (EXP_W=8, FRAC_W=23); the FPU ports are plain vectors.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALIGN   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_NORM    = 3'd3,
    ST_ROUND   = 3'd4,
    ST_OUTPUT  = 3'd5
  } fpu_state_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fpu_flags_t;

  localparam fpu_flags_t FLAGS_NONE = 4'b0000;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter. An all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] count
);

  // Scan upward from the LSB so the highest set bit decides the final count
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      count = value[i] ? CNT_W'(WIDTH - 1 - i) : count;
    end
  end

endmodule

// File: rtl/fpu_multicycle.sv
// Multi-cycle IEEE-754 ADD/SUB/MUL with parametrised widths, round to
// nearest even on guard/round/sticky, special values and exception flags.
// Fixed five-state pipeline behind valid/ready handshakes on both sides.
module fpu_multicycle
  import h2bp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            operation,
  input  logic [EXP_W+FRAC_W:0] operand_a,
  input  logic [EXP_W+FRAC_W:0] operand_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic [3:0]            flags
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M   = FRAC_W + 1;      // mantissa incl. hidden bit
  localparam int SW  = M + 3;           // mantissa plus guard/round/sticky
  localparam int WK  = M + 4;           // working value with carry bit on top
  localparam int EW  = EXP_W + 2;       // signed exponent with headroom
  localparam int LZW = $clog2(SW + 1);
  localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  fpu_state_t           state_r, state_nxt_s;
  logic [2:0]           op_r;
  logic [W-1:0]         a_r, b_r;
  logic                 sign_r, sub_r, special_r;
  logic signed [EW-1:0] exp_r;
  logic [M-1:0]         mx_r;
  logic [SW-1:0]        my_r;
  logic [W-1:0]         spec_res_r;
  fpu_flags_t           spec_flags_r;
  logic [WK-1:0]        work_r;
  logic [W-1:0]         result_r;
  fpu_flags_t           flags_r;

  // unpack / align
  logic                 is_add_s, is_sub_s, is_mul_s;
  logic                 sa_s, sb_s;
  logic [EXP_W-1:0]     ea_s, eb_s, e_big_s, e_small_s, diff_s;
  logic                 zero_a_s, zero_b_s, inf_a_s, inf_b_s, nan_a_s, nan_b_s;
  logic [M-1:0]         ma_s, mb_s, m_big_s, m_small_s;
  logic                 swap_s, s_big_s, s_small_s;
  logic [SW-1:0]        ext_s, sh_s;
  logic                 al_special_s, al_sign_s, al_sub_s;
  logic [W-1:0]         al_res_s;
  fpu_flags_t           al_flags_s;
  logic signed [EW-1:0] al_exp_s;
  logic [M-1:0]         al_mx_s;
  logic [SW-1:0]        al_my_s;
  // compute / normalise / round
  logic [2*M-1:0]       prod_s;
  logic [WK-1:0]        sum_s, mul_work_s, norm_work_s;
  logic [LZW-1:0]       lz_s;
  logic signed [EW-1:0] norm_exp_s, rexp_s;
  logic [M-1:0]         mant_s;
  logic                 rup_s, inexact_s;
  logic [M:0]           rnd_s;
  logic [FRAC_W-1:0]    frac_s;
  logic [W-1:0]         rres_s;
  fpu_flags_t           rflags_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic: fixed walk through the stages, hold in OUTPUT until taken
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    state_nxt_s = in_valid ? ST_ALIGN : ST_IDLE;
      ST_ALIGN:   state_nxt_s = ST_COMPUTE;
      ST_COMPUTE: state_nxt_s = ST_NORM;
      ST_NORM:    state_nxt_s = ST_ROUND;
      ST_ROUND:   state_nxt_s = ST_OUTPUT;
      ST_OUTPUT:  state_nxt_s = out_ready ? ST_IDLE : ST_OUTPUT;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Unpack operands (denormals flush to zero), swap and align the smaller addend
  always_comb begin
    is_add_s  = (op_r == opADD);
    is_sub_s  = (op_r == opSUB);
    is_mul_s  = (op_r == opMUL);
    sa_s      = a_r[W-1];
    sb_s      = b_r[W-1] ^ is_sub_s;
    ea_s      = a_r[W-2:FRAC_W];
    eb_s      = b_r[W-2:FRAC_W];
    zero_a_s  = (ea_s == {EXP_W{1'b0}});
    zero_b_s  = (eb_s == {EXP_W{1'b0}});
    inf_a_s   = (ea_s == {EXP_W{1'b1}}) && (a_r[FRAC_W-1:0] == {FRAC_W{1'b0}});
    inf_b_s   = (eb_s == {EXP_W{1'b1}}) && (b_r[FRAC_W-1:0] == {FRAC_W{1'b0}});
    nan_a_s   = (ea_s == {EXP_W{1'b1}}) && (a_r[FRAC_W-1:0] != {FRAC_W{1'b0}});
    nan_b_s   = (eb_s == {EXP_W{1'b1}}) && (b_r[FRAC_W-1:0] != {FRAC_W{1'b0}});
    ma_s      = zero_a_s ? {M{1'b0}} : {1'b1, a_r[FRAC_W-1:0]};
    mb_s      = zero_b_s ? {M{1'b0}} : {1'b1, b_r[FRAC_W-1:0]};
    swap_s    = {eb_s, mb_s} > {ea_s, ma_s};
    e_big_s   = swap_s ? eb_s : ea_s;
    e_small_s = swap_s ? ea_s : eb_s;
    m_big_s   = swap_s ? mb_s : ma_s;
    m_small_s = swap_s ? ma_s : mb_s;
    s_big_s   = swap_s ? sb_s : sa_s;
    s_small_s = swap_s ? sa_s : sb_s;
    diff_s    = e_big_s - e_small_s;
    ext_s     = {m_small_s, 3'b000};
    if (int'(diff_s) >= SW) begin
      sh_s = {{(SW-1){1'b0}}, |ext_s};
    end else begin
      sh_s    = ext_s >> diff_s;
      sh_s[0] = sh_s[0] | (|(ext_s & ~({SW{1'b1}} << diff_s)));
    end

    if (is_mul_s) begin
      al_sign_s = sa_s ^ sb_s;
      al_sub_s  = 1'b0;
      al_exp_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_E;
      al_mx_s   = ma_s;
      al_my_s   = {3'b000, mb_s};
    end else begin
      al_sign_s = s_big_s;
      al_sub_s  = s_big_s ^ s_small_s;
      al_exp_s  = $signed({2'b00, e_big_s});
      al_mx_s   = m_big_s;
      al_my_s   = sh_s;
    end

    // Special operands bypass the datapath but keep the same latency
    al_special_s = 1'b1;
    al_res_s     = {W{1'b0}};
    al_flags_s   = FLAGS_NONE;
    if (!(is_add_s || is_sub_s || is_mul_s)) begin
      al_flags_s.invalid = 1'b1;
    end else if (nan_a_s || nan_b_s) begin
      al_res_s = QNAN;
    end else if (is_mul_s && ((inf_a_s && zero_b_s) || (zero_a_s && inf_b_s))) begin
      al_res_s           = QNAN;
      al_flags_s.invalid = 1'b1;
    end else if (is_mul_s && (inf_a_s || inf_b_s)) begin
      al_res_s = {sa_s ^ sb_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (is_mul_s && (zero_a_s || zero_b_s)) begin
      al_res_s = {sa_s ^ sb_s, {(W-1){1'b0}}};
    end else if (!is_mul_s && inf_a_s && inf_b_s && (sa_s != sb_s)) begin
      al_res_s           = QNAN;
      al_flags_s.invalid = 1'b1;
    end else if (!is_mul_s && inf_a_s) begin
      al_res_s = {sa_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (!is_mul_s && inf_b_s) begin
      al_res_s = {sb_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (!is_mul_s && zero_a_s && zero_b_s) begin
      al_res_s = {sa_s & sb_s, {(W-1){1'b0}}};
    end else begin
      al_special_s = 1'b0;
    end
  end

  // Magnitude add/subtract and mantissa product; product folds into the working format
  always_comb begin
    prod_s = {{M{1'b0}}, mx_r} * {{M{1'b0}}, my_r[M-1:0]};
    if (sub_r) sum_s = {1'b0, mx_r, 3'b000} - {1'b0, my_r};
    else       sum_s = {1'b0, mx_r, 3'b000} + {1'b0, my_r};
    mul_work_s = {prod_s[2*M-1:M-3], |prod_s[M-4:0]};
  end

  fpu_lzc #(.WIDTH(SW), .CNT_W(LZW)) u_lzc (
    .value (work_r[SW-1:0]),
    .count (lz_s)
  );

  // Normalise: carry shifts right into sticky, otherwise shift out leading zeros
  always_comb begin
    if (work_r[WK-1]) begin
      norm_work_s = {1'b0, work_r[WK-1:2], work_r[1] | work_r[0]};
      norm_exp_s  = exp_r + E_ONE;
    end else begin
      norm_work_s = work_r << lz_s;
      norm_exp_s  = exp_r - $signed({{(EW-LZW){1'b0}}, lz_s});
    end
  end

  // Round to nearest even, then classify overflow/underflow/cancellation
  always_comb begin
    mant_s    = work_r[WK-2:3];
    inexact_s = |work_r[2:0];
    rup_s     = work_r[2] & (work_r[1] | work_r[0] | mant_s[0]);
    rnd_s     = {1'b0, mant_s} + {{M{1'b0}}, rup_s};
    if (rnd_s[M]) begin
      frac_s = rnd_s[M-1:1];
      rexp_s = exp_r + E_ONE;
    end else begin
      frac_s = rnd_s[M-2:0];
      rexp_s = exp_r;
    end
    rres_s   = {W{1'b0}};
    rflags_s = FLAGS_NONE;
    if (special_r) begin
      rres_s   = spec_res_r;
      rflags_s = spec_flags_r;
    end else if (work_r == {WK{1'b0}}) begin
      rres_s = {W{1'b0}};
    end else if (rexp_s >= EMAX_E) begin
      rres_s             = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rflags_s.overflow  = 1'b1;
      rflags_s.inexact   = 1'b1;
    end else if (rexp_s <= $signed({EW{1'b0}})) begin
      rres_s             = {sign_r, {(W-1){1'b0}}};
      rflags_s.underflow = 1'b1;
      rflags_s.inexact   = 1'b1;
    end else begin
      rres_s           = {sign_r, rexp_s[EXP_W-1:0], frac_s};
      rflags_s.inexact = inexact_s;
    end
  end

  // Operand capture, per-stage datapath registers and the held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= 3'd0;
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      sign_r       <= 1'b0;
      sub_r        <= 1'b0;
      special_r    <= 1'b0;
      exp_r        <= {EW{1'b0}};
      mx_r         <= {M{1'b0}};
      my_r         <= {SW{1'b0}};
      spec_res_r   <= {W{1'b0}};
      spec_flags_r <= FLAGS_NONE;
      work_r       <= {WK{1'b0}};
      result_r     <= {W{1'b0}};
      flags_r      <= FLAGS_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r <= operation;
            a_r  <= operand_a;
            b_r  <= operand_b;
          end
        end
        ST_ALIGN: begin
          sign_r       <= al_sign_s;
          sub_r        <= al_sub_s;
          exp_r        <= al_exp_s;
          mx_r         <= al_mx_s;
          my_r         <= al_my_s;
          special_r    <= al_special_s;
          spec_res_r   <= al_res_s;
          spec_flags_r <= al_flags_s;
        end
        ST_COMPUTE: work_r <= (op_r == opMUL) ? mul_work_s : sum_s;
        ST_NORM: begin
          work_r <= norm_work_s;
          exp_r  <= norm_exp_s;
        end
        ST_ROUND: begin
          result_r <= rres_s;
          flags_r  <= rflags_s;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_OUTPUT);
  assign result    = result_r;
  assign flags     = flags_r;

endmodule

// File: tb/tb_fpu_multicycle.sv
// Directed bench for fpu_multicycle: single precision and half precision
// instances sharing one clock and reset.
module tb_fpu_multicycle;
  import h2bp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32;
  logic [2:0]  operation_32;
  logic [31:0] operand_a_32, operand_b_32, result_32;
  logic [3:0]  flags_32;
  logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16;
  logic [2:0]  operation_16;
  logic [15:0] operand_a_16, operand_b_16, result_16;
  logic [3:0]  flags_16;

  int total = 0;
  int bad   = 0;

  fpu_multicycle #(.EXP_W(8), .FRAC_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_32), .in_ready(in_ready_32),
    .operation(operation_32), .operand_a(operand_a_32), .operand_b(operand_b_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32), .result(result_32), .flags(flags_32)
  );

  fpu_multicycle #(.EXP_W(5), .FRAC_W(10)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16),
    .operation(operation_16), .operand_a(operand_a_16), .operand_b(operand_b_16),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .result(result_16), .flags(flags_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op, check latency, result and flags, optionally stall, then take it.
  task automatic run_op(input bit half, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [3:0] exp_flg, input string tag, input int hold);
    int lat;
    check({tag, ".in_ready"}, half ? {31'd0, in_ready_16} : {31'd0, in_ready_32}, 32'd1);
    if (half) begin
      operation_16 = op; operand_a_16 = a[15:0]; operand_b_16 = b[15:0]; in_valid_16 = 1'b1;
    end else begin
      operation_32 = op; operand_a_32 = a; operand_b_32 = b; in_valid_32 = 1'b1;
    end
    @(posedge clk); #1;
    in_valid_16 = 1'b0; in_valid_32 = 1'b0;
    operation_32 = 3'd7; operand_a_32 = 32'hDEADBEEF; operand_b_32 = 32'h12345678;
    operation_16 = 3'd7; operand_a_16 = 16'hBEEF;     operand_b_16 = 16'h1234;
    lat = 0;
    while (((half && !out_valid_16) || (!half && !out_valid_32)) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".result"}, half ? {16'h0000, result_16} : result_32, exp_res);
    check({tag, ".flags"}, half ? {28'd0, flags_16} : {28'd0, flags_32}, {28'd0, exp_flg});
    for (int k = 0; k < hold; k++) begin
      in_valid_32 = 1'b1; operand_a_32 = 32'h3F800000; operand_b_32 = 32'h3F800000;
      operation_32 = opADD;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, {31'd0, out_valid_32}, 32'd1);
      check({tag, ".hold_result"}, result_32, exp_res);
      check({tag, ".hold_flags"}, {28'd0, flags_32}, {28'd0, exp_flg});
      check({tag, ".hold_in_ready"}, {31'd0, in_ready_32}, 32'd0);
    end
    in_valid_32 = 1'b0;
    if (half) out_ready_16 = 1'b1; else out_ready_32 = 1'b1;
    @(posedge clk); #1;
    out_ready_16 = 1'b0; out_ready_32 = 1'b0;
    check({tag, ".back_idle"}, half ? {31'd0, in_ready_16} : {31'd0, in_ready_32}, 32'd1);
    check({tag, ".valid_drop"}, half ? {31'd0, out_valid_16} : {31'd0, out_valid_32}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid_32 = 1'b0; out_ready_32 = 1'b0; operation_32 = 3'd0;
    operand_a_32 = 32'h0; operand_b_32 = 32'h0;
    in_valid_16 = 1'b0; out_ready_16 = 1'b0; operation_16 = 3'd0;
    operand_a_16 = 16'h0; operand_b_16 = 16'h0;
    #3;
    check("reset.in_ready",  {31'd0, in_ready_32},  32'd1);
    check("reset.out_valid", {31'd0, out_valid_32}, 32'd0);
    check("reset.result",    result_32,             32'd0);
    check("reset.flags",     {28'd0, flags_32},     32'd0);
    check("reset16.in_ready", {31'd0, in_ready_16}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic arithmetic
    run_op(1'b0, opADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, "add_1_2", 0);
    run_op(1'b0, opMUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, "mul_1p5_2", 0);
    run_op(1'b0, opADD, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000, "add_carry", 0);
    run_op(1'b0, opSUB, 32'h40000000, 32'h3F800000, 32'h3F800000, 4'b0000, "sub_2_1", 0);
    run_op(1'b0, opSUB, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, "sub_neg", 0);
    run_op(1'b0, opADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000, "denorm_flush", 0);
    // zeros
    run_op(1'b0, opSUB, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, "cancel", 0);
    run_op(1'b0, opADD, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000, "negzero_add", 0);
    run_op(1'b0, opMUL, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, "negzero_mul", 0);
    // rounding
    run_op(1'b0, opADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001, "tie_even_down", 0);
    run_op(1'b0, opADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001, "tie_even_up", 0);
    // exceptions and specials
    run_op(1'b0, opMUL, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, "overflow", 0);
    run_op(1'b0, opMUL, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, "underflow", 0);
    run_op(1'b0, opADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, "inf_minus_inf", 0);
    run_op(1'b0, opMUL, 32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000, "zero_times_inf", 0);
    run_op(1'b0, opADD, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000, "inf_plus_one", 0);
    run_op(1'b0, opADD, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000, "nan_in", 0);
    run_op(1'b0, 3'd7,  32'h3F800000, 32'h3F800000, 32'h00000000, 4'b1000, "bad_opcode", 0);
    // back-pressure: result held for 10 cycles
    run_op(1'b0, opADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, "stall", 10);

    // reset while the operation sits in COMPUTE
    operation_32 = opMUL; operand_a_32 = 32'h3FC00000; operand_b_32 = 32'h40000000;
    in_valid_32 = 1'b1;
    @(posedge clk); #1;
    in_valid_32 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midreset.in_ready",  {31'd0, in_ready_32},  32'd1);
    check("midreset.out_valid", {31'd0, out_valid_32}, 32'd0);
    check("midreset.result",    result_32,             32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("postreset.out_valid", {31'd0, out_valid_32}, 32'd0);
      check("postreset.in_ready",  {31'd0, in_ready_32},  32'd1);
    end
    run_op(1'b0, opADD, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, "after_reset", 0);

    // half precision
    run_op(1'b1, opADD, 32'h00003C00, 32'h00004000, 32'h00004200, 4'b0000, "h_add", 0);
    run_op(1'b1, opMUL, 32'h00003E00, 32'h00004000, 32'h00004200, 4'b0000, "h_mul", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
